mod_step_counter: RTL and testbench

Parametrised up/down modulo counter with a programmable prescaler, wrap or saturate boundary mode, synchronous load/clear, and terminal-count/overflow flags. It generalises the design's free-running 4-bit counter. It is the timing/occurrence counter used by the sequence-detector datapath, for example to count detected patterns or to pace sampling.

---
 rtl/mod_step_counter.sv | 86 ++++++++
 tb/tb_mod_step_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mod_step_counter.sv
// Up/down modulo counter with prescaler, wrap/saturate boundary handling,
// synchronous clear/load, one-cycle terminal-count pulse and sticky overflow.
module mod_step_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 9,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             ps_done;
  logic             step;
  logic             boundary;

  assign ps_done = (ps_q == PS_LAST);
  assign step    = en && ps_done && !clr && !load;
  // Boundary depends on direction: top when counting up, zero when counting down.
  assign boundary = up_dn ? (count_q == MAX_C) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_clr ? 1'b0 : ovf_q;

    if (clr) begin
      count_d = '0;
      ps_d    = '0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
      ps_d    = '0;
    end else if (en) begin
      ps_d = ps_done ? '0 : ps_q + 1'b1;
    end

    if (step) begin
      if (boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (!sat_mode) begin
          count_d = up_dn ? '0 : MAX_C;
        end
      end else begin
        count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed self-checking bench: PRESCALE=1 instance for count/boundary
// behaviour, PRESCALE=3 instance for prescaler pacing.
module tb_mod_step_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat_mode, clr, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] count0, count3;
  logic       tc0, tc3, ovf0, ovf3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mod_step_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count0), .tc(tc0), .ovf(ovf0)
  );

  mod_step_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_p3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
    .count(count3), .tc(tc3), .ovf(ovf3)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; load = 1'b1; clr = 1'b1; load_val = 4'd5;
    up_dn = 1'b1; sat_mode = 1'b0; ovf_clr = 1'b0;
    tick();
    total_cnt++; if (count0 !== 4'd0) $display("FAIL reset_count: got %0d want 0", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf0); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (count0 !== 4'd0) $display("FAIL clr_over_load: got %0d want 0", count0); else pass_cnt++;
    clr = 1'b0; load = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_wrap_up;
    logic [3:0] exp_c;
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_c = 4'((i + 1) % 10);
      total_cnt++; if (count0 !== exp_c) $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, count0, exp_c); else pass_cnt++;
      total_cnt++; if (tc0 !== (exp_c == 4'd0)) $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, tc0, exp_c == 4'd0); else pass_cnt++;
      total_cnt++; if (ovf0 !== (i >= 9)) $display("FAIL wrap_up_ovf[%0d]: got %b want %b", i, ovf0, i >= 9); else pass_cnt++;
    end
    en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_cnt++; if (count0 !== 4'd0) $display("FAIL clr_count: got %0d want 0", count0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b1) $display("FAIL clr_keeps_ovf: got %b want 1", ovf0); else pass_cnt++;
  endtask

  task automatic test_sat_down;
    logic exp_tc [4];
    exp_tc = '{1'b0, 1'b1, 1'b1, 1'b1};
    en = 1'b0; load = 1'b1; load_val = 4'd1; ovf_clr = 1'b1;
    tick();
    load = 1'b0; ovf_clr = 1'b0;
    total_cnt++; if (count0 !== 4'd1) $display("FAIL sat_load: got %0d want 1", count0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL sat_ovf_cleared: got %b want 0", ovf0); else pass_cnt++;
    en = 1'b1; up_dn = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (count0 !== 4'd0) $display("FAIL sat_down_count[%0d]: got %0d want 0", i, count0); else pass_cnt++;
      total_cnt++; if (tc0 !== exp_tc[i]) $display("FAIL sat_down_tc[%0d]: got %b want %b", i, tc0, exp_tc[i]); else pass_cnt++;
      total_cnt++; if (ovf0 !== exp_tc[i]) $display("FAIL sat_down_ovf[%0d]: got %b want %b", i, ovf0, exp_tc[i]); else pass_cnt++;
    end
    ovf_clr = 1'b1;
    tick();
    total_cnt++; if (ovf0 !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL ovf_set_wins_tc: got %b want 1", tc0); else pass_cnt++;
    en = 1'b0;
    tick();
    ovf_clr = 1'b0;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL ovf_clr_alone: got %b want 0", ovf0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b0) $display("FAIL tc_idle: got %b want 0", tc0); else pass_cnt++;
  endtask

  task automatic test_load_clamp;
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b1; load_val = 4'd7;
    tick();
    total_cnt++; if (count0 !== 4'd7) $display("FAIL load_plain: got %0d want 7", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b0) $display("FAIL load_tc: got %b want 0", tc0); else pass_cnt++;
    load_val = 4'd14;
    tick();
    load = 1'b0;
    total_cnt++; if (count0 !== 4'd9) $display("FAIL load_clamp: got %0d want 9", count0); else pass_cnt++;
    tick();
    total_cnt++; if (count0 !== 4'd0) $display("FAIL clamp_wrap_count: got %0d want 0", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL clamp_wrap_tc: got %b want 1", tc0); else pass_cnt++;
  endtask

  task automatic test_down_wrap;
    en = 1'b1; up_dn = 1'b0; sat_mode = 1'b0;
    tick();
    total_cnt++; if (count0 !== 4'd9) $display("FAIL down_wrap_count: got %0d want 9", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL down_wrap_tc: got %b want 1", tc0); else pass_cnt++;
    up_dn = 1'b1;
    tick();
    total_cnt++; if (count0 !== 4'd0) $display("FAIL toggle_up_count: got %0d want 0", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL toggle_up_tc: got %b want 1", tc0); else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++; if (count0 !== 4'd0) $display("FAIL hold_count: got %0d want 0", count0); else pass_cnt++;
    total_cnt++; if (tc0 !== 1'b0) $display("FAIL tc_one_cycle: got %b want 0", tc0); else pass_cnt++;
  endtask

  task automatic test_prescale;
    logic [3:0] exp_stall [8];
    logic       en_stall  [8];
    logic [3:0] exp_load  [3];
    logic [3:0] exp_rst   [3];
    exp_stall = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    en_stall  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_load  = '{4'd5, 4'd5, 4'd6};
    exp_rst   = '{4'd0, 4'd0, 4'd1};

    up_dn = 1'b1; sat_mode = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      total_cnt++; if (count3 !== 4'(e / 3)) $display("FAIL ps_count[%0d]: got %0d want %0d", e, count3, e / 3); else pass_cnt++;
      total_cnt++; if (tc3 !== 1'b0) $display("FAIL ps_tc[%0d]: got %b want 0", e, tc3); else pass_cnt++;
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      en = en_stall[e];
      tick();
      total_cnt++; if (count3 !== exp_stall[e]) $display("FAIL ps_stall[%0d]: got %0d want %0d", e, count3, exp_stall[e]); else pass_cnt++;
    end

    en = 1'b1;
    tick();
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      total_cnt++; if (count3 !== exp_load[e]) $display("FAIL ps_load[%0d]: got %0d want %0d", e, count3, exp_load[e]); else pass_cnt++;
    end

    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (count3 !== 4'd0) $display("FAIL ps_rst_count: got %0d want 0", count3); else pass_cnt++;
    for (int e = 0; e < 3; e++) begin
      tick();
      total_cnt++; if (count3 !== exp_rst[e]) $display("FAIL ps_after_rst[%0d]: got %0d want %0d", e, count3, exp_rst[e]); else pass_cnt++;
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_down_wrap();
    test_prescale();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
